// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - funct3 load/store width codes (DM_*)
//   - FSM state encoding for mem_access_unit
//   - access-size decode helper; undefined funct3 codes fall back to word
package mem_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    // 011, 110 and 111 have no defined width and are handled as a word.
    function automatic mem_size_e dm_size(input logic [2:0] ctrl);
        case (ctrl)
            DM_B, DM_BU: dm_size = SZ_B;
            DM_H, DM_HU: dm_size = SZ_H;
            default:     dm_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load-data formatter.
//   rdata  in  32  raw word from the data bus
//   off    in  2   byte offset of the access within the word
//   ctrl   in  3   funct3 (B/H/W/BU/HU); bit 2 selects zero extension
//   data   out 32  lane-selected, sign/zero-extended load value
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ctrl,
    output logic [31:0] data
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        lane_b = 8'sd0;
        lane_h = 16'sd0;
        data   = rdata;
        case (off)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = off[1] ? rdata[31:16] : rdata[15:0];
        case (dm_size(ctrl))
            SZ_B:    data = ctrl[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_H:    data = ctrl[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit (single outstanding
// request). Turns a load/store into one data-bus transaction, stalls the
// pipeline until it is acknowledged and formats the load result.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   mem_valid_in      instruction present in MEM
//   mem_read_in       load
//   mem_write_in      store (wins over mem_read_in)
//   dm_ctrl_in        funct3 width code
//   addr_in           byte address
//   wdata_in          store data
//   read_data_out     registered formatted load data (0 after a store)
//   stall_out         freeze the upstream pipeline
//   misalign_out      misaligned access detected (trap build only)
//   dbus_req/we/addr/be/wdata   registered bus request
//   dbus_ack, dbus_rdata        bus response
//
// Build option MISALIGN_TRAP_EN: when defined a misaligned access is refused
// and flagged on misalign_out; when undefined the address is force-aligned
// and the access proceeds.
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  dm_ctrl_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic [31:0] read_data_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    mem_state_e  state;
    mem_size_e   size;
    logic        access;
    logic        accept;
    logic        trap;
    logic [31:0] addr_eff;
    logic [1:0]  off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [2:0]  ctrl_q;
    logic [1:0]  off_q;
    logic [31:0] load_data;

    // Request decode, address alignment and store lane steering
    always_comb begin
        size     = dm_size(dm_ctrl_in);
        access   = mem_valid_in & (mem_read_in | mem_write_in);
        addr_eff = addr_in;
`ifdef MISALIGN_TRAP_EN
        trap   = (state == IDLE) && access && !rst &&
                 (((size == SZ_H) && addr_in[0]) ||
                  ((size == SZ_W) && (addr_in[1:0] != 2'b00)));
        accept = (state == IDLE) && access && !rst && !trap;
`else
        trap = 1'b0;
        if (size == SZ_H) addr_eff[0]   = 1'b0;
        if (size == SZ_W) addr_eff[1:0] = 2'b00;
        accept = (state == IDLE) && access && !rst;
`endif
        off = addr_eff[1:0];
        case (size)
            SZ_B: begin
                be_next    = 4'b0001 << off;
                wdata_next = {4{wdata_in[7:0]}};
            end
            SZ_H: begin
                be_next    = off[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata_in[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata_in;
            end
        endcase
    end

    // Accept cycle stalls combinationally; BUSY stalls through the ack cycle.
    assign stall_out    = accept | (state == BUSY);
    assign misalign_out = trap;

    mem_load_ext u_load_ext (
        .rdata (dbus_rdata),
        .off   (off_q),
        .ctrl  (ctrl_q),
        .data  (load_data)
    );

    // Access FSM and registered bus interface
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dbus_req      <= 1'b0;
            dbus_we       <= 1'b0;
            dbus_addr     <= 32'd0;
            dbus_be       <= 4'd0;
            dbus_wdata    <= 32'd0;
            read_data_out <= 32'd0;
            ctrl_q        <= 3'd0;
            off_q         <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_write_in;
                        dbus_addr  <= {addr_eff[31:2], 2'b00};
                        dbus_be    <= be_next;
                        dbus_wdata <= wdata_next;
                        ctrl_q     <= dm_ctrl_in;
                        off_q      <= off;
                        state      <= BUSY;
                    end else if (trap) begin
                        read_data_out <= 32'd0;
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        dbus_req      <= 1'b0;
                        read_data_out <= dbus_we ? 32'd0 : load_data;
                        state         <= DONE;
                    end
                end
                // One bubble cycle: the held instruction is not re-issued.
                DONE: state <= IDLE;
                default: begin
                    dbus_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit of the 5-stage RISC-V pipeline, sitting between EX_MEM and MEM_WB. It turns a load/store from the MEM stage into a single-outstanding request on the data bus, stalls the pipeline until the bus acknowledges, and aligns and extends load data. The formatted data then drives `read_data_in` of MEM_WB.

## Interface
- No parameters; bus width fixed at 32, byte-addressed.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_valid_in  in  1  an instruction occupies MEM this cycle.
- mem_read_in  in  1  the instruction is a load.
- mem_write_in  in  1  the instruction is a store.
- dm_ctrl_in  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_in  in  32  byte address (ALU result).
- wdata_in  in  32  store data (rs2).
- read_data_out  out  32  formatted load data to MEM_WB; registered.
- stall_out  out  1  freeze PC/IF_ID/ID_EX/EX_MEM; the top also zeroes RegWrite into MEM_WB.
- misalign_out  out  1  misaligned access detected.
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word-aligned address, low 2 bits 0.
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-replicated store data.
- dbus_ack  in  1  request completes this cycle.
- dbus_rdata  in  32  read word, valid when dbus_ack.

## Operation
- Access = mem_valid_in & (mem_read_in | mem_write_in). If both read and write are set, the write wins.
- FSM states:
  - IDLE: on a legal access, register addr/be/wdata/we/ctrl/offset, go BUSY. stall_out=1 combinationally this cycle.
  - BUSY: dbus_req=1, with all dbus_* outputs held stable from the registers. stall_out=1. On dbus_ack, go DONE; for a load, capture the formatted dbus_rdata into read_data_out.
  - DONE: stall_out=0 and dbus_req=0 for exactly one cycle, and inputs are ignored, so the same instruction is never re-issued. Go IDLE.
- Store lanes, off=addr[1:0]:
  - SB: be=1<<off, wdata={4{wdata[7:0]}}.
  - SH: be=off[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111.
- Load formatting:
  - B/BU: byte lane off, sign- or zero-extended.
  - H/HU: halfword lane off[1], sign- or zero-extended.
  - W: whole word.
- A completed store sets read_data_out to 0.
- Misaligned: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0. See Configuration.
- Undefined dm_ctrl codes (011, 110, 111) are treated as W.

## Timing
- Reset values: state IDLE, read_data_out 0, dbus_req 0, dbus_we 0, dbus_addr 0, dbus_be 0, dbus_wdata 0, misalign_out 0, stall_out 0.
- Access accepted at cycle T. dbus_req is high from T+1 until and including the ack cycle T+k (k≥1). DONE is at T+k+1.
- MEM_WB latches read_data_out at the end of DONE.
- Minimum stall is 2 cycles (ack in the first BUSY cycle). Stall lasts k+1 cycles in general.
- dbus_ack outside BUSY is ignored.
- rst mid-BUSY drops dbus_req immediately; the outstanding request is abandoned, and the bus must tolerate this.
- Back-to-back accesses: the next instruction reaches MEM in the cycle after DONE and is sampled in IDLE.

## Configuration
- MISALIGN_TRAP_EN defined:
  - A misaligned access in IDLE raises misalign_out for one cycle, combinationally.
  - No bus request, no stall, state stays IDLE.
  - read_data_out is set to 0 at the next edge.
  - A misaligned store has no memory effect.
- MISALIGN_TRAP_EN undefined:
  - misalign_out is tied 0.
  - The address is force-aligned: H clears bit 0, W clears bits 1:0.
  - The access proceeds normally.

## Structure
- Shared package mem_pkg holds:
  - funct3 constants: DM_B, DM_H, DM_W, DM_BU, DM_HU.
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One combinational sub-module, mem_load_ext, takes (rdata, off, ctrl) and returns the extended data.

## Test plan
- LW at 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF: stall high 4 cycles, dbus_be=1111, read_data_out=0xDEADBEEF in DONE.
- LB at 0x103 with rdata 0x80FF0011: read_data_out 0xFFFFFF80. LBU at the same address: 0x00000080.
- SH at 0x202 with wdata 0x1234ABCD: dbus_addr 0x200, be 1100, dbus_wdata 0xABCDABCD, dbus_we=1, read_data_out=0.
- Two back-to-back LW, each acked in the first BUSY cycle: each stalls 2 cycles; exactly two dbus_req assertions, with DONE between them.
- rst asserted in the second BUSY cycle: dbus_req and stall_out drop the same cycle; after reset the next LW issues normally.
- LW at 0x101:
  - With MISALIGN_TRAP_EN: misalign_out pulses for 1 cycle, no dbus_req, no stall.
  - Without it: dbus_addr 0x100, normal completion.
